// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ID/EX control path: FSM encoding, bubble value
// and the bit layout of the packed control bundle.
package cpu_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [31:0] NOOP_CTRL_DEF = '0;

    localparam int F_ALUOP_LSB = 0;
    localparam int F_ALUOP_W   = 4;
    localparam int F_REGWR     = 4;
    localparam int F_MEMRD     = 5;
    localparam int F_MEMWR     = 6;
    localparam int F_BRANCH    = 7;
    localparam int F_MULDIV    = 8;

    function automatic logic [31:0] pack_ctrl(input logic [F_ALUOP_W-1:0] aluop,
                                              input logic regwr, input logic memrd,
                                              input logic memwr, input logic branch,
                                              input logic muldiv);
        logic [31:0] c;
        c = '0;
        c[F_ALUOP_LSB +: F_ALUOP_W] = aluop;
        c[F_REGWR]  = regwr;
        c[F_MEMRD]  = memrd;
        c[F_MEMWR]  = memwr;
        c[F_BRANCH] = branch;
        c[F_MULDIV] = muldiv;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_bubble_reg_if.sv
// ID-side inputs and EX-side outputs of the control-bundle register.
// master drives the decoded instruction, slave is the register itself.
interface ctrl_bubble_reg_if #(
    parameter int CTRL_W = 32,
    parameter int REG_AW = 5,
    parameter int LAT_W  = 5,
    parameter int BCNT_W = 16
);
    logic [CTRL_W-1:0] ID_Ctrl;
    logic              ID_Valid;
    logic [REG_AW-1:0] ID_Rs;
    logic [REG_AW-1:0] ID_Rt;
    logic              ID_UsesRt;
    logic [REG_AW-1:0] ID_Dst;
    logic              ID_MemRead;
    logic              ID_MultiCycle;
    logic [LAT_W-1:0]  ID_MultiLat;
    logic              Flush;

    logic [CTRL_W-1:0] EX_Ctrl;
    logic [REG_AW-1:0] EX_Dst;
    logic              EX_MemRead;
    logic              EX_Valid;
    logic              Stall_IF;
    logic              Busy;
    logic [BCNT_W-1:0] Bubble_Count;

    modport master (
        output ID_Ctrl, ID_Valid, ID_Rs, ID_Rt, ID_UsesRt, ID_Dst, ID_MemRead,
               ID_MultiCycle, ID_MultiLat, Flush,
        input  EX_Ctrl, EX_Dst, EX_MemRead, EX_Valid, Stall_IF, Busy, Bubble_Count
    );

    modport slave (
        input  ID_Ctrl, ID_Valid, ID_Rs, ID_Rt, ID_UsesRt, ID_Dst, ID_MemRead,
               ID_MultiCycle, ID_MultiLat, Flush,
        output EX_Ctrl, EX_Dst, EX_MemRead, EX_Valid, Stall_IF, Busy, Bubble_Count
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
// Purely combinational; register 0 never creates a dependency.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_uses_rt,
    input  logic              i_ex_valid,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_ex_dst,
    output logic              o_hazard
);
    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ex_dst == i_id_rs);
    assign w_rt_match = i_id_uses_rt & (i_ex_dst == i_id_rt);

    assign o_hazard = i_id_valid & i_ex_valid & i_ex_memread & (i_ex_dst != '0)
                    & (w_rs_match | w_rt_match);

endmodule

// File: rtl/ctrl_bubble_reg.sv
// ID/EX control register: per cycle advances the ID bundle, inserts a bubble, or holds.
// EX outputs update one edge after ID; Stall_IF is combinational for hazards and BUSY.
module ctrl_bubble_reg
    import cpu_ctrl_pkg::*;
#(
    parameter int                CTRL_W    = 32,
    parameter int                REG_AW    = 5,
    parameter logic [CTRL_W-1:0] NOOP_CTRL = CTRL_W'(NOOP_CTRL_DEF),
    parameter int                LAT_W     = 5,
    parameter int                BCNT_W    = 16
) (
    input logic           Clk,
    input logic           Reset_n,
    ctrl_bubble_reg_if.slave bus
);
    state_e            r_state;
    logic [LAT_W-1:0]  r_cnt;
    logic              r_flush_pend;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [REG_AW-1:0] r_ex_dst;
    logic              r_ex_memread;
    logic              r_ex_valid;
    logic [BCNT_W-1:0] r_bcnt;

    logic w_hazard;
    logic w_flush_eff;
    logic w_long_op;

    load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .i_id_valid   (bus.ID_Valid),
        .i_id_rs      (bus.ID_Rs),
        .i_id_rt      (bus.ID_Rt),
        .i_id_uses_rt (bus.ID_UsesRt),
        .i_ex_valid   (r_ex_valid),
        .i_ex_memread (r_ex_memread),
        .i_ex_dst     (r_ex_dst),
        .o_hazard     (w_hazard)
    );

    assign w_flush_eff = bus.Flush | r_flush_pend;
    // Latencies of 0 or 1 behave as ordinary single-cycle instructions.
    assign w_long_op   = bus.ID_Valid & bus.ID_MultiCycle & (bus.ID_MultiLat >= LAT_W'(2));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_ex_ctrl    <= NOOP_CTRL;
            r_ex_dst     <= '0;
            r_ex_memread <= 1'b0;
            r_ex_valid   <= 1'b0;
            r_bcnt       <= '0;
        end else if (r_state == BUSY) begin
            // EX holds the long instruction; a flush here is remembered for the held ID slot.
            if (bus.Flush) r_flush_pend <= 1'b1;
            if (r_cnt == LAT_W'(1)) begin
                r_state <= RUN;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt - LAT_W'(1);
            end
        end else begin
            r_flush_pend <= 1'b0;
            if (w_flush_eff || w_hazard) begin
                r_ex_ctrl    <= NOOP_CTRL;
                r_ex_dst     <= '0;
                r_ex_memread <= 1'b0;
                r_ex_valid   <= 1'b0;
                if (bus.ID_Valid && (r_bcnt != '1)) r_bcnt <= r_bcnt + BCNT_W'(1);
            end else begin
                r_ex_ctrl    <= bus.ID_Ctrl;
                r_ex_dst     <= bus.ID_Dst;
                r_ex_memread <= bus.ID_MemRead;
                r_ex_valid   <= bus.ID_Valid;
                if (w_long_op) begin
                    r_state <= BUSY;
                    r_cnt   <= bus.ID_MultiLat - LAT_W'(1);
                end
            end
        end
    end

    assign bus.EX_Ctrl      = r_ex_ctrl;
    assign bus.EX_Dst       = r_ex_dst;
    assign bus.EX_MemRead   = r_ex_memread;
    assign bus.EX_Valid     = r_ex_valid;
    assign bus.Busy         = (r_state == BUSY);
    assign bus.Stall_IF     = (r_state == BUSY) | (w_hazard & ~w_flush_eff);
    assign bus.Bubble_Count = r_bcnt;

endmodule

// File: tb/tb_ctrl_bubble_reg.sv
// Scoreboarded random + directed bench for ctrl_bubble_reg (16-bit and 4-bit counter instances).
module tb_ctrl_bubble_reg;
    import cpu_ctrl_pkg::*;

    localparam int CW = 32;
    localparam int AW = 5;
    localparam int LW = 5;

    logic          Clk;
    logic          Reset_n;
    logic [CW-1:0] id_ctrl;
    logic          id_valid, id_usesrt, id_memrd, id_mc, flush;
    logic [AW-1:0] id_rs, id_rt, id_dst;
    logic [LW-1:0] id_lat;

    ctrl_bubble_reg_if #(.CTRL_W(CW), .REG_AW(AW), .LAT_W(LW), .BCNT_W(16)) ifa ();
    ctrl_bubble_reg_if #(.CTRL_W(CW), .REG_AW(AW), .LAT_W(LW), .BCNT_W(4))  ifb ();

    assign ifa.ID_Ctrl = id_ctrl;     assign ifb.ID_Ctrl = id_ctrl;
    assign ifa.ID_Valid = id_valid;   assign ifb.ID_Valid = id_valid;
    assign ifa.ID_Rs = id_rs;         assign ifb.ID_Rs = id_rs;
    assign ifa.ID_Rt = id_rt;         assign ifb.ID_Rt = id_rt;
    assign ifa.ID_UsesRt = id_usesrt; assign ifb.ID_UsesRt = id_usesrt;
    assign ifa.ID_Dst = id_dst;       assign ifb.ID_Dst = id_dst;
    assign ifa.ID_MemRead = id_memrd; assign ifb.ID_MemRead = id_memrd;
    assign ifa.ID_MultiCycle = id_mc; assign ifb.ID_MultiCycle = id_mc;
    assign ifa.ID_MultiLat = id_lat;  assign ifb.ID_MultiLat = id_lat;
    assign ifa.Flush = flush;         assign ifb.Flush = flush;

    ctrl_bubble_reg #(.CTRL_W(CW), .REG_AW(AW), .LAT_W(LW), .BCNT_W(16)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .bus(ifa.slave));
    ctrl_bubble_reg #(.CTRL_W(CW), .REG_AW(AW), .LAT_W(LW), .BCNT_W(4)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .bus(ifb.slave));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what EX holds, how many hold cycles remain, pending flush, bubble total.
    typedef struct {
        logic          stall;
        logic          busy;
        logic          vld;
        logic          mem;
        logic [CW-1:0] ctrl;
        logic [AW-1:0] dst;
        int            bubbles;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] m_ctrl;
    logic [AW-1:0] m_dst;
    logic          m_mem, m_vld, m_pend;
    int            m_hold, m_bubbles;

    function automatic void model_reset();
        m_ctrl = '0; m_dst = '0; m_mem = 1'b0; m_vld = 1'b0;
        m_pend = 1'b0; m_hold = 0; m_bubbles = 0;
    endfunction

    function automatic void model_step();
        exp_t e;
        bit   kill, dep;
        kill = flush || m_pend;
        dep  = id_valid && m_vld && m_mem && (m_dst != 0) &&
               ((m_dst == id_rs) || (id_usesrt && (m_dst == id_rt)));
        e.busy = (m_hold > 0);
        e.stall = (m_hold > 0) ? 1'b1 : (dep && !kill);
        e.vld = m_vld; e.mem = m_mem; e.ctrl = m_ctrl; e.dst = m_dst;
        e.bubbles = m_bubbles;
        sb.push_back(e);
        if (m_hold > 0) begin
            if (flush) m_pend = 1'b1;
            m_hold--;
        end else if (kill || dep) begin
            m_ctrl = '0; m_dst = '0; m_mem = 1'b0; m_vld = 1'b0; m_pend = 1'b0;
            if (id_valid) m_bubbles++;
        end else begin
            m_ctrl = id_ctrl; m_dst = id_dst; m_mem = id_memrd; m_vld = id_valid;
            if (id_valid && id_mc && id_lat >= 2) m_hold = int'(id_lat) - 1;
        end
    endfunction

    task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt, input logic urt, input logic [AW-1:0] d,
                       input logic mr, input logic mc, input logic [LW-1:0] lat, input logic fl);
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_usesrt = urt;
        id_dst = d; id_memrd = mr; id_mc = mc; id_lat = lat; flush = fl;
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl_a"}, ifa.EX_Ctrl, 32'(NOOP_CTRL_DEF));
        chk({tag, "_dst_a"}, 32'(ifa.EX_Dst), 32'd0);
        chk({tag, "_mem_a"}, 32'(ifa.EX_MemRead), 32'd0);
        chk({tag, "_vld_a"}, 32'(ifa.EX_Valid), 32'd0);
        chk({tag, "_busy_a"}, 32'(ifa.Busy), 32'd0);
        chk({tag, "_bcnt_a"}, 32'(ifa.Bubble_Count), 32'd0);
        chk({tag, "_bcnt_b"}, 32'(ifb.Bubble_Count), 32'd0);
    endtask

    // Monitor: every negedge the DUTs present outputs and the oldest expectation is retired.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall_a", 32'(ifa.Stall_IF), 32'(e.stall));
                chk("busy_a", 32'(ifa.Busy), 32'(e.busy));
                chk("exvld_a", 32'(ifa.EX_Valid), 32'(e.vld));
                chk("exmem_a", 32'(ifa.EX_MemRead), 32'(e.mem));
                chk("exctrl_a", ifa.EX_Ctrl, e.ctrl);
                chk("exdst_a", 32'(ifa.EX_Dst), 32'(e.dst));
                chk("bcnt_a", 32'(ifa.Bubble_Count), 32'((e.bubbles > 65535) ? 65535 : e.bubbles));
                chk("bcnt_b", 32'(ifb.Bubble_Count), 32'((e.bubbles > 15) ? 15 : e.bubbles));
                chk("stall_b", 32'(ifb.Stall_IF), 32'(e.stall));
                chk("exctrl_b", ifb.EX_Ctrl, e.ctrl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [CW-1:0] lw_c, add_c, mul_c;

    initial begin
        Reset_n = 1'b0;
        id_valid = 0; id_ctrl = '0; id_rs = '0; id_rt = '0; id_usesrt = 0;
        id_dst = '0; id_memrd = 0; id_mc = 0; id_lat = '0; flush = 0;
        model_reset();
        lw_c  = pack_ctrl(4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_c = pack_ctrl(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mul_c = pack_ctrl(4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #3;
        chk_reset_outputs("rst0");
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Load-use on r5, then a load to r0 which must not stall.
        cyc(1, lw_c,  5'd1, 5'd0, 0, 5'd5, 1, 0, 5'd0, 0);
        cyc(1, add_c, 5'd5, 5'd2, 1, 5'd6, 0, 0, 5'd0, 0);
        cyc(1, add_c, 5'd5, 5'd2, 1, 5'd6, 0, 0, 5'd0, 0);
        cyc(1, lw_c,  5'd1, 5'd0, 0, 5'd0, 1, 0, 5'd0, 0);
        cyc(1, add_c, 5'd0, 5'd0, 1, 5'd7, 0, 0, 5'd0, 0);
        // Rt-only dependency.
        cyc(1, lw_c,  5'd1, 5'd0, 0, 5'd9, 1, 0, 5'd0, 0);
        cyc(1, add_c, 5'd3, 5'd9, 1, 5'd4, 0, 0, 5'd0, 0);
        cyc(1, add_c, 5'd3, 5'd9, 1, 5'd4, 0, 0, 5'd0, 0);

        // Four-cycle multiply, then latency 1 which must not enter BUSY.
        cyc(1, mul_c, 5'd1, 5'd2, 1, 5'd3, 0, 1, 5'd4, 0);
        repeat (4) cyc(1, add_c, 5'd3, 5'd0, 0, 5'd8, 0, 0, 5'd0, 0);
        cyc(1, mul_c, 5'd1, 5'd2, 1, 5'd3, 0, 1, 5'd1, 0);
        cyc(1, add_c, 5'd3, 5'd0, 0, 5'd8, 0, 0, 5'd0, 0);

        // Flush in the first BUSY cycle of a latency-3 op squashes the held ID slot.
        cyc(1, mul_c, 5'd1, 5'd2, 1, 5'd3, 0, 1, 5'd3, 0);
        cyc(1, add_c, 5'd4, 5'd0, 0, 5'd8, 0, 0, 5'd0, 1);
        cyc(1, add_c, 5'd4, 5'd0, 0, 5'd8, 0, 0, 5'd0, 0);
        cyc(1, add_c, 5'd4, 5'd0, 0, 5'd8, 0, 0, 5'd0, 0);
        cyc(1, add_c, 5'd4, 5'd0, 0, 5'd8, 0, 0, 5'd0, 0);

        // Flush coincident with a load-use hazard, and with a multi-cycle op in RUN.
        cyc(1, lw_c,  5'd1, 5'd0, 0, 5'd7, 1, 0, 5'd0, 0);
        cyc(1, add_c, 5'd7, 5'd0, 0, 5'd2, 0, 0, 5'd0, 1);
        cyc(1, mul_c, 5'd1, 5'd2, 1, 5'd3, 0, 1, 5'd5, 1);
        cyc(0, '0,    5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);

        // Asynchronous reset in the middle of a BUSY period.
        cyc(1, mul_c, 5'd1, 5'd2, 1, 5'd3, 0, 1, 5'd4, 0);
        chk("midbusy_busy", 32'(ifa.Busy), 32'd1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        chk("rst_mid_stall", 32'(ifa.Stall_IF), 32'd0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Twenty forced bubbles: the 4-bit counter pins at 15.
        repeat (20) cyc(1, add_c, 5'd1, 5'd2, 1, 5'd3, 0, 0, 5'd0, 1);
        cyc(0, '0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);

        repeat (600) begin
            cyc(($urandom_range(9) < 8), $urandom,
                5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)),
                5'($urandom_range(3)), ($urandom_range(9) < 4), ($urandom_range(9) < 1),
                5'($urandom_range(6)), ($urandom_range(9) < 1));
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge Clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_bubble_reg.md
Name: ctrl_bubble_reg

Overview:
- Parametrised ID/EX control-bundle register that decides per cycle whether the decoded control word advances, becomes a bubble, or is held.
- Adds load-use hazard detection, multi-cycle EX occupancy (mult/div), branch-flush squashing with a pending-flush latch, and a saturating bubble counter.
- Sits between the decoder output and the EX stage. Drives the stall enable for the PC and IF/ID registers.

Parameters:
- CTRL_W, 32, width of the packed control bundle.
- REG_AW, 5, register-index width.
- NOOP_CTRL, {CTRL_W{1'b0}}, bubble value loaded into EX.
- LAT_W, 5, width of the multi-cycle latency field.
- BCNT_W, 16, width of the bubble counter.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ID_Ctrl  in  CTRL_W  decoded control bundle of the ID instruction.
- ID_Valid  in  1  ID holds a real instruction.
- ID_Rs  in  REG_AW  source register 1.
- ID_Rt  in  REG_AW  source register 2.
- ID_UsesRt  in  1  instruction reads Rt.
- ID_Dst  in  REG_AW  destination register.
- ID_MemRead  in  1  instruction is a load.
- ID_MultiCycle  in  1  instruction occupies EX for more than one cycle.
- ID_MultiLat  in  LAT_W  total EX cycles for a multi-cycle instruction.
- Flush  in  1  squash the instruction currently presented on ID.
- EX_Ctrl  out  CTRL_W  registered control bundle for EX.
- EX_Dst  out  REG_AW  registered destination register.
- EX_MemRead  out  1  registered load flag.
- EX_Valid  out  1  EX holds a real instruction.
- Stall_IF  out  1  hold PC and IF/ID this cycle.
- Busy  out  1  FSM is in BUSY.
- Bubble_Count  out  BCNT_W  number of bubbles inserted, saturating.

Behaviour:
- Reset (asynchronous, active-low; applies mid-operation too):
  - EX_Ctrl=NOOP_CTRL; EX_Dst=0; EX_MemRead=0; EX_Valid=0.
  - State=RUN; cnt=0; flush_pend=0; Bubble_Count=0.
- Definitions:
  - flush_eff = Flush | flush_pend.
  - hazard = ID_Valid & EX_Valid & EX_MemRead & (EX_Dst!=0) & ((EX_Dst==ID_Rs) | (ID_UsesRt & EX_Dst==ID_Rt)).
- States: RUN, BUSY.
- RUN, priority order at each rising edge:
  1. flush_eff: EX loads bubble (EX_Ctrl=NOOP_CTRL, Dst=0, MemRead=0, Valid=0); flush_pend cleared; Stall_IF=0.
  2. hazard: EX loads bubble; Stall_IF=1 (combinational, same cycle).
  3. Otherwise: EX loads ID_Ctrl, ID_Dst, ID_MemRead, and EX_Valid=ID_Valid; Stall_IF=0.
     - If ID_Valid & ID_MultiCycle & ID_MultiLat>=2: next state BUSY, cnt=ID_MultiLat-1.
     - ID_MultiLat of 0 or 1 is treated as a single-cycle instruction.
- BUSY:
  - EX registers hold; Stall_IF=1; Busy=1.
  - cnt==1 at the edge: next state RUN, cnt=0. Otherwise cnt decrements.
  - The multi-cycle instruction therefore occupies EX for exactly ID_MultiLat cycles.
  - Flush in BUSY sets flush_pend; the held ID instruction is squashed on the first RUN cycle.
- Bubble_Count:
  - Increments by 1 on every edge where EX loads a bubble because of flush_eff or hazard while ID_Valid=1.
  - Saturates at all-ones.
  - BUSY hold cycles are not counted.
- Simultaneous events:
  - Flush with hazard: flush wins, no stall.
  - Flush with a multi-cycle ID instruction in RUN: squashed, no BUSY entry.
- Hazard and Stall_IF are combinational from ports and registers. All other outputs are registered.

Decomposition:
- Shared package (cpu_ctrl_pkg):
  - FSM state encoding (RUN=1'b0, BUSY=1'b1).
  - Default NOOP_CTRL constant.
  - Control-bundle field offsets used to pack ID_Ctrl.
- One natural sub-module: load_use_detect, the purely combinational hazard compare.
- FSM, counter and EX register stay in the top module.

Test Plan:
- Reset with Reset_n=0 mid-BUSY (cnt=3) -> all outputs return to reset values immediately, without waiting for a clock edge; State=RUN.
- Load-use:
  - Stimulus: lw with ID_Dst=5, ID_MemRead=1, enters EX; next ID has Rs=5.
  - Response: Stall_IF=1 for exactly one cycle; EX_Valid=0 for one cycle; Bubble_Count 0->1; the instruction enters EX on the following edge.
  - Repeat with EX_Dst=0 -> no stall.
- Multi-cycle:
  - Stimulus: ID_MultiCycle=1, ID_MultiLat=4.
  - Response: EX_Ctrl holds the same value 4 cycles; Busy=1 and Stall_IF=1 for 3 cycles; next instruction loads on the 4th edge.
  - Repeat with ID_MultiLat=1 -> no BUSY.
- Flush during BUSY (ID_MultiLat=3; Flush=1 in first BUSY cycle) -> first RUN edge loads bubble, EX_Valid=0, Bubble_Count+1, flush_pend cleared.
- Flush together with hazard in the same cycle -> Stall_IF=0; EX bubble; Bubble_Count+1 (not +2).
- Saturation: BCNT_W=4, 20 forced bubbles -> Bubble_Count stays at 15.
